// File: rtl/scsa_err_correct_pkg.sv
// Shared constants, FSM state type and the misspeculation combiner for the
// SCSA error detector/corrector.
package scsa_pkg;

    localparam int N = 8;      // operand width
    localparam int K = 2;      // sub-adder block width
    localparam int M = N / K;  // number of blocks

    typedef enum logic [1:0] {
        IDLE,
        FIX,
        OUT
    } state_t;

    // A speculative block carry is wrong exactly when some block propagates
    // across its whole width while the block below it generates a carry:
    // the speculated carry (G of the lower block alone) then misses the
    // ripple into the propagating run.
    function automatic logic err_from_pg(input logic [M-1:0] p, input logic [M-1:0] g);
        logic e;
        e = 1'b0;
        for (int j = 1; j < M; j++) begin
            e = e | (p[j] & g[j-1]);
        end
        return e;
    endfunction

endpackage

// File: rtl/scsa_err_correct_block_pg.sv
// Block propagate / generate for one K-bit slice of the SCSA adder.
module scsa_block_pg #(
    parameter int K = 2
) (
    input  logic [K-1:0] a,
    input  logic [K-1:0] b,
    output logic         p,
    output logic         g
);

    logic [K:0] blk_sum;

    assign blk_sum = {1'b0, a} + {1'b0, b};
    assign p       = &(a ^ b);
    assign g       = blk_sum[K];

endmodule

// File: rtl/scsa_err_correct.sv
// Variable-latency corrector behind the SCSA approximate adder. Exact results
// pass straight through in one cycle; misspeculated ones take a FIX cycle
// where the exact sum is recomputed. Valid/ready on the output side.
module scsa_err_correct #(
    parameter int N  = scsa_pkg::N,
    parameter int K  = scsa_pkg::K,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N-1:0]  a,
    input  logic [N-1:0]  b,
    input  logic [N-1:0]  approx_sum,
    input  logic          approx_cout,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [N-1:0]  sum,
    output logic          cout,
    output logic          err_flag,
    output logic [CW-1:0] err_count
);

    localparam int M = N / K;

    import scsa_pkg::*;

    state_t        state;
    state_t        state_next;
    logic [M-1:0]  p_blk;
    logic [M-1:0]  g_blk;
    logic          err_in;
    logic          accept;
    logic [N-1:0]  a_p0;
    logic [N-1:0]  b_p0;
    logic [CW-1:0] cnt_max;

    for (genvar j = 0; j < M; j++) begin : g_pg
        scsa_block_pg #(.K(K)) u_pg (
            .a (a[j*K +: K]),
            .b (b[j*K +: K]),
            .p (p_blk[j]),
            .g (g_blk[j])
        );
    end

    assign err_in    = err_from_pg(p_blk, g_blk);
    assign cnt_max   = '1;
    assign out_valid = (state == OUT);
    assign accept    = in_valid & in_ready;

    // Ready depends only on state, out_ready and reset; never on in_valid.
    always_comb begin
        in_ready = 1'b0;
        case (state)
            IDLE:    in_ready = 1'b1;
            OUT:     in_ready = out_ready;
            default: in_ready = 1'b0;
        endcase
        in_ready = in_ready & rst_n;
    end

    // Next-state: accepted transactions go to FIX on misspeculation, else OUT.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) state_next = err_in ? FIX : OUT;
            end
            FIX: begin
                state_next = OUT;
            end
            OUT: begin
                if (out_ready) begin
                    if (accept) state_next = err_in ? FIX : OUT;
                    else        state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Operand capture for the FIX recompute.
    always_ff @(posedge clk) begin
        if (accept) begin
            a_p0 <= a;
            b_p0 <= b;
        end
    end

    // Result register: pass-through on accept when exact, exact add in FIX.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sum      <= '0;
            cout     <= 1'b0;
            err_flag <= 1'b0;
        end else if (state == FIX) begin
            {cout, sum} <= {1'b0, a_p0} + {1'b0, b_p0};
            err_flag    <= 1'b1;
        end else if (accept && !err_in) begin
            sum      <= approx_sum;
            cout     <= approx_cout;
            err_flag <= 1'b0;
        end
    end

    // Saturating count of corrections, bumped on the FIX edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_count <= '0;
        end else if (state == FIX && err_count != cnt_max) begin
            err_count <= err_count + {{(CW-1){1'b0}}, 1'b1};
        end
    end

endmodule
